// File: rtl/uart_rx_core_if.sv
// Register-file side of the UART receiver: read/clear strobes in, holding register and flags out.
interface uart_rx_core_if;
    logic       rd;
    logic       oerr_clr;
    logic [7:0] rx_data;
    logic       UxRXIF;
    logic       FERR;
    logic       OERR;
    logic       PERR;

    modport master (output rd, oerr_clr, input rx_data, UxRXIF, FERR, OERR, PERR);
    modport slave  (input rd, oerr_clr, output rx_data, UxRXIF, FERR, OERR, PERR);
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1 deserialiser with one-deep holding register, FERR and sticky OERR.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report PERR.
module uart_rx_core #(
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             UxRX,
    input  logic [DIV_W-1:0] brg_div,
    input  logic             rx_en,
    output logic             busy,
    uart_rx_core_if.slave    rf
);
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        LOAD
    } state_t;

    state_t           state_reg, state_next;
    logic             sync_reg [2];
    logic             rxs, rxs_prev_reg;
    logic [DIV_W-1:0] div_reg, div_next, timer_reg, timer_next, div_clamped;
    logic [2:0]       bitcnt_reg, bitcnt_next;
    logic [7:0]       shift_reg, shift_next, rx_data_reg, rx_data_next;
    logic             stop_reg, stop_next;
    logic             rxif_reg, rxif_next, ferr_reg, ferr_next, oerr_reg, oerr_next;
    logic             expired;
`ifdef UART_RX_PARITY_EN
    logic             par_reg, par_next, perr_reg, perr_next;
`endif

    // Two-flop synchroniser, idle-high so reset never looks like a start edge
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= UxRX;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b1;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rxs         = sync_reg[1];
    assign expired     = (timer_reg == '0);
    assign div_clamped = (brg_div < MIN_DIV_V) ? MIN_DIV_V : brg_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rxs_prev_reg <= 1'b1;
            div_reg      <= '0;
            timer_reg    <= '0;
            bitcnt_reg   <= '0;
            shift_reg    <= '0;
            stop_reg     <= 1'b0;
            rx_data_reg  <= '0;
            rxif_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            oerr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rxs_prev_reg <= rxs;
            div_reg      <= div_next;
            timer_reg    <= timer_next;
            bitcnt_reg   <= bitcnt_next;
            shift_reg    <= shift_next;
            stop_reg     <= stop_next;
            rx_data_reg  <= rx_data_next;
            rxif_reg     <= rxif_next;
            ferr_reg     <= ferr_next;
            oerr_reg     <= oerr_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_reg  <= 1'b0;
            perr_reg <= 1'b0;
        end else begin
            par_reg  <= par_next;
            perr_reg <= perr_next;
        end
    end
`endif

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        timer_next   = expired ? '0 : timer_reg - DIV_W'(1);
        bitcnt_next  = bitcnt_reg;
        shift_next   = shift_reg;
        stop_next    = stop_reg;
        rx_data_next = rx_data_reg;
        rxif_next    = rxif_reg;
        ferr_next    = ferr_reg;
        oerr_next    = oerr_reg;
`ifdef UART_RX_PARITY_EN
        par_next     = par_reg;
        perr_next    = perr_reg;
`endif
        // CPU strobes first so that a load in the same cycle overrides them
        if (rf.rd)       rxif_next = 1'b0;
        if (rf.oerr_clr) oerr_next = 1'b0;

        if (!rx_en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (rxs_prev_reg && !rxs) begin
                    div_next   = div_clamped;
                    timer_next = div_clamped >> 1;
                    state_next = START;
                end
                START: if (expired) begin
                    if (rxs) begin
                        state_next = IDLE;
                    end else begin
                        timer_next  = div_reg;
                        bitcnt_next = '0;
                        state_next  = DATA;
                    end
                end
                DATA: if (expired) begin
                    shift_next  = {rxs, shift_reg[7:1]};
                    timer_next  = div_reg;
                    bitcnt_next = bitcnt_reg + 3'd1;
                    if (bitcnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (expired) begin
                    par_next   = ^{shift_reg, rxs};
                    timer_next = div_reg;
                    state_next = STOP;
                end
`endif
                STOP: if (expired) begin
                    stop_next  = rxs;
                    state_next = LOAD;
                end
                LOAD: begin
                    state_next = IDLE;
                    if (!rxif_reg || rf.rd) begin
                        rx_data_next = shift_reg;
                        ferr_next    = !stop_reg;
                        rxif_next    = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next    = par_reg;
`endif
                    end else begin
                        oerr_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign rf.rx_data = rx_data_reg;
    assign rf.UxRXIF  = rxif_reg;
    assign rf.FERR    = ferr_reg;
    assign rf.OERR    = oerr_reg;
`ifdef UART_RX_PARITY_EN
    assign rf.PERR    = perr_reg;
`else
    assign rf.PERR    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frame-level reference model, busy-fall / CPU-strobe monitor.
module tb_uart_rx_core;
    localparam int DIV_W = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NB = PAR_EN ? 11 : 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             UxRX;
    logic [DIV_W-1:0] brg_div;
    logic             rx_en;
    logic             busy;

    uart_rx_core_if bus ();

    uart_rx_core #(.DIV_W(DIV_W), .MIN_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .UxRX    (UxRX),
        .brg_div (brg_div),
        .rx_en   (rx_en),
        .busy    (busy),
        .rf      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] regs;
        int          exp_cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [7:0] m_data;
    logic       m_if, m_ferr, m_oerr, m_perr;

    always @(posedge clk) cyc++;

    function automatic logic [11:0] model_regs();
        return {m_data, m_if, m_ferr, m_oerr, m_perr};
    endfunction

    // Cycle (relative to the start-bit drive) at which LOAD completes
    function automatic int load_len(input int n);
        return 14 + n / 2 + 9 * n + (PAR_EN ? n + 1 : 0);
    endfunction

    function automatic logic line_bit(input int b, input logic [7:0] d, input logic p, input logic s);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR_EN && b == 9) return p;
        return s;
    endfunction

    task automatic push_exp(input int ec, input string nm);
        exp_t e;
        e.regs    = model_regs();
        e.exp_cyc = ec;
        e.name    = nm;
        sbq.push_back(e);
    endtask

    task automatic send_frame(input int n, input logic [DIV_W-1:0] div_val, input logic [7:0] data,
                              input logic par, input logic stop, input bit rd_load,
                              input int abort_j, input string nm);
        int c, len, total;
        len = load_len(n);
        brg_div = div_val;
        @(negedge clk);
        c = cyc;
        if (abort_j >= 0) begin
            push_exp(c + abort_j + 1, nm);
        end else begin
            if (!m_if || rd_load) begin
                m_data = data;
                m_ferr = !stop;
                m_perr = PAR_EN ? ^{data, par} : 1'b0;
                m_if   = 1'b1;
            end else begin
                m_oerr = 1'b1;
            end
            push_exp(c + len, nm);
        end
        total = ((NB * (n + 1) > len) ? NB * (n + 1) : len) + 3;
        for (int j = 0; j < total; j++) begin
            if (j > 0) @(negedge clk);
            UxRX   = (j < NB * (n + 1)) ? line_bit(j / (n + 1), data, par, stop) : 1'b1;
            bus.rd = rd_load && (abort_j < 0) && (j == len - 1);
            if (j == 3) brg_div = DIV_W'($urandom);
            if (j == abort_j) rx_en = 1'b0;
        end
        UxRX  = 1'b1;
        rx_en = 1'b1;
        $display("[TB] sent %s n=%0d data=%h stop=%0d par=%0d rd_load=%0d", nm, n, data, stop, par, rd_load);
    endtask

    task automatic cpu_op(input logic r, input logic clr, input string nm);
        @(negedge clk);
        bus.rd       = r;
        bus.oerr_clr = clr;
        if (r)   m_if   = 1'b0;
        if (clr) m_oerr = 1'b0;
        push_exp(cyc + 1, nm);
        @(negedge clk);
        bus.rd       = 1'b0;
        bus.oerr_clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic glitch(input int n);
        int c;
        brg_div = DIV_W'(n);
        @(negedge clk);
        c    = cyc;
        UxRX = 1'b0;
        push_exp(c + 4 + n / 2, "glitch");
        repeat (3) @(negedge clk);
        UxRX = 1'b1;
        repeat (n + 8) @(negedge clk);
        $display("[TB] sent glitch n=%0d", n);
    endtask

    // Monitor: every busy fall or CPU strobe is one observable transaction
    initial begin
        logic        busy_prev;
        logic        op;
        logic [11:0] act;
        exp_t        e;
        busy_prev = 1'b0;
        forever begin
            @(posedge clk);
            op = bus.rd || bus.oerr_clr;
            #1;
            if (!rst && ((busy_prev && !busy) || op)) begin
                act = {bus.rx_data, bus.UxRXIF, bus.FERR, bus.OERR, bus.PERR};
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: regs=%h at cyc %0d, no expectation queued", act, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (act !== e.regs) begin
                        fails++;
                        $display("FAIL %s regs: got %h (data/if/ferr/oerr/perr) want %h", e.name, act, e.regs);
                    end
                    if (e.exp_cyc >= 0) begin
                        tests++;
                        if (cyc != e.exp_cyc) begin
                            fails++;
                            $display("FAIL %s timing: event at cyc %0d want %0d", e.name, cyc, e.exp_cyc);
                        end
                    end
                    $display("[TB] check %s regs=%h cyc=%0d", e.name, act, cyc);
                end
            end
            busy_prev = rst ? 1'b0 : busy;
        end
    end

    initial begin
        int          n, dv, wait_cnt;
        logic [7:0]  d;
        logic        r, clr;
        logic [12:0] rst_act;
        rst          = 1'b1;
        UxRX         = 1'b1;
        rx_en        = 1'b1;
        brg_div      = DIV_W'(16);
        bus.rd       = 1'b0;
        bus.oerr_clr = 1'b0;
        m_data = 8'h00; m_if = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0; m_perr = 1'b0;
        repeat (4) @(negedge clk);
        rst_act = {bus.rx_data, bus.UxRXIF, bus.FERR, bus.OERR, bus.PERR, busy};
        tests++;
        if (rst_act !== 13'd0) begin
            fails++;
            $display("FAIL reset: got %h want 0000", rst_act);
        end
        $display("[TB] reset regs+busy=%h", rst_act);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_frame(16, 16, 8'hA5, 1'b0, 1'b1, 1'b0, -1, "8n1_a5");
        cpu_op(1'b1, 1'b0, "rd_a5");
        glitch(16);
        send_frame(16, 16, 8'h3C, 1'b0, 1'b0, 1'b0, -1, "ferr_3c");
        cpu_op(1'b1, 1'b0, "rd_3c");
        send_frame(16, 16, 8'h11, 1'b0, 1'b1, 1'b0, -1, "ovr_11");
        send_frame(16, 16, 8'h22, 1'b0, 1'b1, 1'b0, -1, "ovr_22");
        cpu_op(1'b0, 1'b1, "oerr_clr");
        send_frame(16, 16, 8'h33, 1'b0, 1'b1, 1'b1, -1, "rdload_33");
        cpu_op(1'b1, 1'b0, "rd_33");
        send_frame(16, 16, 8'h77, 1'b0, 1'b1, 1'b0, 5 * 17, "abort_77");
        send_frame(4, 1, 8'h5A, 1'b0, 1'b1, 1'b0, -1, "clamp_5a");
        cpu_op(1'b1, 1'b0, "rd_5a");
        if (PAR_EN) begin
            send_frame(8, 8, 8'h07, 1'b1, 1'b1, 1'b0, -1, "par_ok_07");
            cpu_op(1'b1, 1'b0, "rd_p1");
            send_frame(8, 8, 8'h07, 1'b0, 1'b1, 1'b0, -1, "par_bad_07");
            cpu_op(1'b1, 1'b0, "rd_p2");
        end

        for (int i = 0; i < 20; i++) begin
            dv = $urandom_range(0, 24);
            n  = (dv < 4) ? 4 : dv;
            d  = 8'($urandom);
            send_frame(n, DIV_W'(dv), d, 1'($urandom), $urandom_range(0, 7) != 0,
                       $urandom_range(0, 3) == 0, -1, "rand");
            r   = $urandom_range(0, 1) == 1;
            clr = $urandom_range(0, 3) == 0;
            if (r || clr) cpu_op(r, clr, "rand_cpu");
        end

        wait_cnt = 0;
        while (sbq.size() != 0 && wait_cnt < 500) begin
            @(negedge clk);
            wait_cnt++;
        end
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
